// File: rtl/seg_display_bank.sv
// seg_display_bank
// Avalon-MM slave holding one segment pattern per seven-segment digit.
// Supports per-digit atomic set/clear, a global blank and optional
// hardware per-digit blinking. All digits are driven in parallel on out_port.
//
// Optional feature macro: SEG_BLINK_EN
//   defined     : blink counter, blink phase and BLINK_MASK are implemented
//   not defined : phase is constant 0, BLINK_MASK reads 0, its writes are ignored
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     word address (4 bits)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (32 bits)
//   readdata    read data, combinational from address, zero wait states
//   out_port    digit i on bits [i*SEG_W +: SEG_W], polarity set by ACTIVE_LOW
//
// Address map
//   0..NUM_DIGITS-1  DATA[i]    RW
//   8                BLINK_MASK RW
//   9                BLANK      RW
//   10               STATUS     RO  bit0 blink phase, [11:8] NUM_DIGITS
//   12               OUTSET     WO  DATA[wd[18:16]] |=  wd[SEG_W-1:0]
//   13               OUTCLEAR   WO  DATA[wd[18:16]] &= ~wd[SEG_W-1:0]

module seg_display_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int SEG_W      = 7,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic [NUM_DIGITS*SEG_W-1:0] out_port
);

    localparam logic [3:0] ADDR_BLINK    = 4'd8;
    localparam logic [3:0] ADDR_BLANK    = 4'd9;
    localparam logic [3:0] ADDR_STATUS   = 4'd10;
    localparam logic [3:0] ADDR_OUTSET   = 4'd12;
    localparam logic [3:0] ADDR_OUTCLEAR = 4'd13;

    logic                        wr;
    logic [SEG_W-1:0]            data [NUM_DIGITS];
    logic                        blank;
    logic [NUM_DIGITS-1:0]       blink_mask;
    logic                        phase;
    logic [2:0]                  mod_idx;
    logic [SEG_W-1:0]            mod_bits;
    logic [NUM_DIGITS*SEG_W-1:0] disp_next;
    logic                        unused_cfg;

    assign wr       = chipselect & ~write_n;
    assign mod_idx  = writedata[18:16];
    assign mod_bits = writedata[SEG_W-1:0];

    // Only part of writedata is decoded; BLINK_DIV is unused without blinking.
    assign unused_cfg = ^{writedata, 32'(BLINK_DIV)};

    // Digit registers and blank. An OUTSET/OUTCLEAR index outside the bank
    // never matches any digit, so it is dropped without an explicit range check.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                data[i] <= '0;
            end
            blank <= 1'b0;
        end else if (wr) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == 4'(i)) begin
                    data[i] <= mod_bits;
                end else if (address == ADDR_OUTSET && mod_idx == 3'(i)) begin
                    data[i] <= data[i] | mod_bits;
                end else if (address == ADDR_OUTCLEAR && mod_idx == 3'(i)) begin
                    data[i] <= data[i] & ~mod_bits;
                end
            end
            if (address == ADDR_BLANK) begin
                blank <= writedata[0];
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] blink_cnt;

    // A BLINK_MASK write restarts the blink cycle, taking priority over a
    // terminal count in the same cycle so the new mask starts in the lit half.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
        end else if (wr && address == ADDR_BLINK) begin
            blink_mask <= writedata[NUM_DIGITS-1:0];
            blink_cnt  <= '0;
            phase      <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    assign blink_mask = '0;
    assign phase      = 1'b0;
`endif

    always_comb begin
        disp_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            disp_next[i*SEG_W +: SEG_W] = (blank || (blink_mask[i] && phase)) ? '0 : data[i];
        end
        if (ACTIVE_LOW) begin
            disp_next = ~disp_next;
        end
    end

    // Registered output keeps the pins glitch-free; it lags the registers by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= ACTIVE_LOW ? '1 : '0;
        end else begin
            out_port <= disp_next;
        end
    end

    // Reads return 0 while reset is held, including STATUS.
    always_comb begin
        readdata = '0;
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == 4'(i)) begin
                    readdata = 32'(data[i]);
                end
            end
            case (address)
                ADDR_BLINK:  readdata = 32'(blink_mask);
                ADDR_BLANK:  readdata = {31'd0, blank};
                ADDR_STATUS: readdata = {20'd0, 4'(NUM_DIGITS), 7'd0, phase};
                default:     ;
            endcase
        end
    end

endmodule

// File: doc/seg_display_bank.md
# seg_display_bank

Parametrised Avalon-MM slave driving a bank of seven-segment digits for the alarm-clock SoC, replacing one single-digit PIO per display with one register-mapped peripheral. Holds one segment pattern per digit, supports per-digit atomic set/clear, a global blank and hardware per-digit blinking for time-set mode. All digits are output in parallel, one SEG_W slice per digit, with selectable output polarity.

## Interface

- NUM_DIGITS, 6: number of digits, legal 1..8.
- SEG_W, 7: segment bits per digit, legal 1..8.
- BLINK_DIV, 25000000: clk cycles per blink half-period, legal ≥2.
- ACTIVE_LOW, 1: 1 = a lit segment drives 0 on out_port.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  4  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address, zero wait states.
- out_port  out  NUM_DIGITS*SEG_W  digit i on bits [i*SEG_W +: SEG_W].

## Operation

- Write strobe = chipselect & ~write_n; registers update on that clk edge.
- Address map:
  - 0..NUM_DIGITS-1 DATA[i] (RW): write loads writedata[SEG_W-1:0].
  - 8 BLINK_MASK (RW): bits [NUM_DIGITS-1:0]; 1 = digit blinks.
  - 9 BLANK (RW): bit0 = blank all digits.
  - 10 STATUS (RO): bit0 = blink phase, bits [11:8] = NUM_DIGITS.
  - 12 OUTSET (WO): DATA[writedata[18:16]] |= writedata[SEG_W-1:0].
  - 13 OUTCLEAR (WO): DATA[writedata[18:16]] &= ~writedata[SEG_W-1:0].
- OUTSET/OUTCLEAR with index ≥ NUM_DIGITS: ignored.
- Unmapped addresses (incl. NUM_DIGITS..7, 11, 14, 15): read 0, writes ignored. WO registers read 0.
- Unused readdata bits are 0.
- Blink: counter 0..BLINK_DIV-1; at BLINK_DIV-1 it wraps to 0 and phase toggles. Phase 1 = off half.
- Displayed digit i = (BLANK | (BLINK_MASK[i] & phase)) ? 0 : DATA[i]; inverted per digit when ACTIVE_LOW=1.
- Any write to BLINK_MASK clears counter and phase to 0.

## Timing

- Reset: DATA, BLINK_MASK, BLANK, counter, phase = 0; out_port = all ones if ACTIVE_LOW else all zeros; readdata = 0 for every address.
- Reset asserted mid-operation overrides any same-cycle write.
- Write at edge N: register readable from cycle N+1; out_port reflects it after edge N+1 (out_port is registered, one cycle behind the registers).
- Phase toggles every BLINK_DIV cycles; full blink period 2*BLINK_DIV cycles.
- BLINK_MASK write coinciding with terminal count: the write wins (counter 0, phase 0).
- Blanking or unblanking changes out_port after the next edge; DATA contents are preserved.

## Configuration

- SEG_BLINK_EN defined: counter, phase and BLINK_MASK are implemented as above.
- Not defined: no counter; phase is constant 0; BLINK_MASK reads 0 and writes are ignored; STATUS bit0 reads 0; all other behaviour is unchanged.

## Test plan

- Reset, NUM_DIGITS=6, ACTIVE_LOW=1 -> out_port = 42'h3FF_FFFF_FFFF; reads of addresses 0..15 return 0; STATUS after reset release = 0x0600.
- Write DATA[2]=0x5B -> readdata@2 = 0x5B from the next cycle; out_port[20:14] = 0x24 one edge later; other digits unchanged.
- DATA[0]=0x10, OUTSET 0x0000_0003 then OUTCLEAR 0x0000_0010 -> DATA[0] = 0x13, then 0x03. OUTSET with index 7 -> no change.
- BLINK_DIV=4, BLINK_MASK=0x01, DATA[0]=0x7F -> digit 0 alternates lit/dark every 4 cycles; digit 1 steady; BLINK_MASK rewrite during the off half -> phase 0 next cycle.
- BLANK=1 -> all digits dark, DATA readback intact; BLANK=0 -> previous patterns return after one edge.
- Write DATA[1]=0x3F with reset high in the same cycle -> DATA[1] = 0 after the edge.
